// File: rtl/vmem_ldsel_seq.sv
// Strided vector-load sequencer placed ahead of the vector memory crossbar.
// It turns base/stride/vl into one request per distinct memory line. For each
// line it provides the per-lane crossbar selects and lane write-enables.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | pick the line of the lowest pending lane and gather the lanes on that line
// REQ   | request outstanding; outputs held until mem_ack
// DONE  | one-cycle completion pulse
module vmem_ldsel_seq #(
    parameter int INWIDTH      = 128,
    parameter int LOG2INWIDTH  = 7,
    parameter int OUTWIDTH     = 8,
    parameter int LOG2OUTWIDTH = 3,
    parameter int NUMOUTS      = 16,
    parameter int LOG2NUMOUTS  = 4,
    parameter int ADDRWIDTH    = 32,
    parameter int SELWIDTH     = LOG2INWIDTH - LOG2OUTWIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDRWIDTH-1:0]          base,
    input  logic [ADDRWIDTH-1:0]          stride,
    input  logic [LOG2NUMOUTS:0]          vl,
    output logic                          busy,
    output logic                          done,
    output logic                          mem_req,
    output logic [ADDRWIDTH-SELWIDTH-1:0] mem_addr,
    input  logic                          mem_ack,
    output logic [SELWIDTH*NUMOUTS-1:0]   xbar_sel,
    output logic [NUMOUTS-1:0]            lane_we
);

    localparam int LINEWIDTH = ADDRWIDTH - SELWIDTH;
    localparam int VLWIDTH   = LOG2NUMOUTS + 1;

    // The log2 parameters must agree with the widths they describe.
    if (((1 << LOG2INWIDTH) != INWIDTH) || ((1 << LOG2OUTWIDTH) != OUTWIDTH) ||
        ((1 << LOG2NUMOUTS) != NUMOUTS)) begin : g_param_check
        $error("vmem_ldsel_seq: log2 parameters inconsistent with widths");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state;
    logic [ADDRWIDTH-1:0]     lane_addr [NUMOUTS];
    logic [NUMOUTS-1:0]       pending;
    logic [NUMOUTS-1:0]       mask;

    logic                     scan_found;
    logic [LINEWIDTH-1:0]     scan_line;
    logic [NUMOUTS-1:0]       scan_match;
    logic [SELWIDTH*NUMOUTS-1:0] scan_sel;

    // Line of the lowest pending lane, plus every pending lane sharing that line.
    always_comb begin
        scan_found = 1'b0;
        scan_line  = '0;
        scan_match = '0;
        scan_sel   = '0;
        for (int i = 0; i < NUMOUTS; i++) begin
            if (pending[i] && !scan_found) begin
                scan_found = 1'b1;
                scan_line  = lane_addr[i][ADDRWIDTH-1:SELWIDTH];
            end
        end
        for (int i = 0; i < NUMOUTS; i++) begin
            if (pending[i] && (lane_addr[i][ADDRWIDTH-1:SELWIDTH] == scan_line)) begin
                scan_match[i] = 1'b1;
                scan_sel[i*SELWIDTH +: SELWIDTH] = lane_addr[i][SELWIDTH-1:0];
            end
        end
    end

    // Lanes capture only in the cycle the memory returns the requested line.
    assign lane_we = (state == REQ) ? (mask & {NUMOUTS{mem_ack}}) : '0;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            xbar_sel <= '0;
            pending  <= '0;
            mask     <= '0;
            for (int i = 0; i < NUMOUTS; i++) begin
                lane_addr[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUMOUTS; i++) begin
                            lane_addr[i] <= base + ADDRWIDTH'(i) * stride;
                            pending[i]   <= (VLWIDTH'(i) < vl);
                        end
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (pending == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        mem_addr <= scan_line;
                        xbar_sel <= scan_sel;
                        mask     <= scan_match;
                        mem_req  <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        pending <= pending & ~mask;
                        mem_req <= 1'b0;
                        state   <= SCAN;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
